// File: rtl/trace_emitter.sv
// Execution trace emitter: turns register/memory activity into records in a small
// dual-push FIFO, then appends cycle/instruction/drop summaries after Halt.
module trace_emitter #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic [2:0]  WriteRegister,
  input  logic [15:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] MemAddress,
  input  logic [15:0] MemDataIn,
  input  logic [15:0] MemDataOut,
  input  logic        Halt,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [2:0]  rec_type,
  output logic [15:0] rec_a,
  output logic [15:0] rec_b,
  output logic        overflow,
  output logic        trace_done
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, HALTED, SUMMARY, DONE} state_t;
  typedef struct packed {
    logic [2:0]  typ;
    logic [15:0] a;
    logic [15:0] b;
  } rec_t;

  state_t        state, nextState;
  rec_t          mem [DEPTH];
  rec_t          head, regEv, memEv, sumEv, ev0, ev1;
  logic [AW-1:0] wrPtr, rdPtr, wrPtr1;
  logic [AW:0]   count, freeSlots;
  logic [31:0]   cycleCount, instCount, dropCount, sumVal;
  logic [32:0]   dropSum;
  logic [1:0]    sumIdx, nEv, nPush, nDrop;
  logic          pop;

  assign rec_valid  = (count != '0);
  assign pop        = rec_valid && rec_ready;
  assign freeSlots  = (AW+1)'(DEPTH) - count;
  assign wrPtr1     = wrPtr + AW'(1);
  assign head       = mem[rdPtr];
  assign rec_type   = rec_valid ? head.typ : '0;
  assign rec_a      = rec_valid ? head.a : '0;
  assign rec_b      = rec_valid ? head.b : '0;
  assign trace_done = (state == DONE);
  assign dropSum    = {1'b0, dropCount} + {31'b0, nDrop};

  // Event selection; accepted events always fill slots in order, so drops hit the later one first.
  always_comb begin
    regEv = {3'd0, 13'b0, WriteRegister, WriteData};
    memEv = MemWrite ? {3'd2, MemAddress, MemDataIn} : {3'd1, MemAddress, MemDataOut};
    case (sumIdx)
      2'd0:    sumVal = cycleCount;
      2'd1:    sumVal = instCount;
      default: sumVal = dropCount;
    endcase
    sumEv = {3'd3 + {1'b0, sumIdx}, sumVal[31:16], sumVal[15:0]};
    ev0   = regEv;
    ev1   = memEv;
    nEv   = 2'd0;
    if (state == RUN) begin
      if (RegWrite) begin
        nEv = 2'd1 + {1'b0, MemRead | MemWrite};
      end else begin
        ev0 = memEv;
        nEv = {1'b0, MemRead | MemWrite};
      end
    end else if (state == SUMMARY && sumIdx != 2'd3) begin
      ev0 = sumEv;
      nEv = 2'd1;
    end
    nPush = ((AW+1)'(nEv) > freeSlots) ? freeSlots[1:0] : nEv;
    nDrop = (state == RUN) ? nEv - nPush : 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= nextState;
  end

  // Leaving SUMMARY: SUMDROP already pushed and it is the last entry being popped.
  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (Halt) nextState = HALTED;
      HALTED:  if (count == '0) nextState = SUMMARY;
      SUMMARY: if (sumIdx == 2'd3 && pop && count == (AW+1)'(1)) nextState = DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      cycleCount <= '0;
      instCount  <= '0;
      dropCount  <= '0;
      overflow   <= 1'b0;
      sumIdx     <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(nPush);
      rdPtr <= rdPtr + AW'(pop);
      count <= count + (AW+1)'(nPush) - (AW+1)'(pop);
      if (state == RUN) begin
        cycleCount <= cycleCount + 32'd1;
        if (Halt || RegWrite || MemWrite) instCount <= instCount + 32'd1;
        dropCount <= dropSum[32] ? '1 : dropSum[31:0];
        if (nDrop != 2'd0) overflow <= 1'b1;
      end
      if (state == SUMMARY && nPush != 2'd0) sumIdx <= sumIdx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (nPush != 2'd0) mem[wrPtr]  <= ev0;
    if (nPush == 2'd2) mem[wrPtr1] <= ev1;
  end
endmodule
